// File: rtl/grid_game_pkg.sv
// Shared encodings for the grid game controller: FSM states, winner codes and overlay colours.
package grid_game_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_CHECK = 3'd3,
        ST_WIN   = 3'd4,
        ST_DRAW  = 3'd5
    } state_t;

    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] BLACK  = 12'h000;
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] RICE   = 12'hFEB;
    localparam logic [11:0] GREEN  = 12'h0F0;
    localparam logic [11:0] YELLOW = 12'hFF0;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/grid_game_controller_win_checker.sv
// Combinational line detector: flags any full row, column or diagonal in one player's
// N*N ownership mask and returns the union of all completed lines.
module grid_win_checker #(
    parameter int N = 3
) (
    input  logic [N*N-1:0] mask_i,
    output logic           win_o,
    output logic [N*N-1:0] line_mask_o
);

    logic [N-1:0] row_full;
    logic [N-1:0] col_full;
    logic [N-1:0] diag_bits;
    logic [N-1:0] anti_bits;
    logic         diag_full;
    logic         anti_full;

    for (genvar r = 0; r < N; r++) begin : g_line
        logic [N-1:0] rbits;
        logic [N-1:0] cbits;
        for (genvar c = 0; c < N; c++) begin : g_bit
            assign rbits[c] = mask_i[r*N + c];
            assign cbits[c] = mask_i[c*N + r];
        end
        assign row_full[r]  = &rbits;
        assign col_full[r]  = &cbits;
        assign diag_bits[r] = mask_i[r*N + r];
        assign anti_bits[r] = mask_i[r*N + (N-1-r)];
    end

    assign diag_full = &diag_bits;
    assign anti_full = &anti_bits;
    assign win_o     = (|row_full) | (|col_full) | diag_full | anti_full;

    for (genvar r = 0; r < N; r++) begin : g_mr
        for (genvar c = 0; c < N; c++) begin : g_mc
            logic on_d;
            logic on_a;
            if (r == c) begin : g_d
                assign on_d = diag_full;
            end else begin : g_nd
                assign on_d = 1'b0;
            end
            if (r + c == N - 1) begin : g_a
                assign on_a = anti_full;
            end else begin : g_na
                assign on_a = 1'b0;
            end
            assign line_mask_o[r*N + c] = row_full[r] | col_full[c] | on_d | on_a;
        end
    end

endmodule

// File: rtl/grid_game_controller.sv
// N x N two-player placement game with combinational VGA overlay.
// Optional GRID_WIN_HIGHLIGHT_EN paints the winning line(s) yellow while in WIN.
module grid_game_controller
    import grid_game_pkg::*;
#(
    parameter int N        = 3,
    parameter int CELL     = 100,
    parameter int GAP      = 5,
    parameter int ORIGIN_X = 308,
    parameter int ORIGIN_Y = 120
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       first_player,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       btn_sel,
    input  logic                       bright,
    input  logic [9:0]                 hcount,
    input  logic [9:0]                 vcount,
    output logic [11:0]                rgb,
    output logic [$clog2(N)-1:0]       cur_row,
    output logic [$clog2(N)-1:0]       cur_col,
    output logic                       turn,
    output logic [$clog2(N*N+1)-1:0]   move_count,
    output logic [1:0]                 winner,
    output logic [2:0]                 state_q
);

    localparam int RW    = $clog2(N);
    localparam int NN    = N * N;
    localparam int IW    = $clog2(NN);
    localparam int CW    = $clog2(NN + 1);
    localparam int PITCH = CELL + GAP;
    localparam logic [RW-1:0] CTR  = RW'(N / 2);
    localparam logic [RW-1:0] LAST = RW'(N - 1);

    state_t        st_q, st_d;
    logic [NN-1:0] occ_q, occ_d, own_q, own_d;
    logic [RW-1:0] row_q, row_d, col_q, col_d;
    logic          turn_q, turn_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    win_q, win_d;
    logic          clear;
    logic          any_btn;
    logic [IW-1:0] cur_idx;
    logic [NN-1:0] mover_mask, line_mask;
    logic          line_win;

    assign any_btn    = btn_up | btn_down | btn_left | btn_right | btn_sel;
    assign cur_idx    = IW'(row_q) * IW'(N) + IW'(col_q);
    // owner bit set means P2; the checker sees only the current mover's marks
    assign mover_mask = turn_q ? (occ_q & own_q) : (occ_q & ~own_q);

    grid_win_checker #(.N(N)) u_win (
        .mask_i      (mover_mask),
        .win_o       (line_win),
        .line_mask_o (line_mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= ST_INIT;
            occ_q  <= '0;
            own_q  <= '0;
            row_q  <= CTR;
            col_q  <= CTR;
            turn_q <= 1'b0;
            cnt_q  <= '0;
            win_q  <= WIN_NONE;
        end else begin
            st_q   <= st_d;
            occ_q  <= occ_d;
            own_q  <= own_d;
            row_q  <= row_d;
            col_q  <= col_d;
            turn_q <= turn_d;
            cnt_q  <= cnt_d;
            win_q  <= win_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        occ_d  = occ_q;
        own_d  = own_q;
        row_d  = row_q;
        col_d  = col_q;
        turn_d = turn_q;
        cnt_d  = cnt_q;
        win_d  = win_q;
        clear  = 1'b0;
        case (st_q)
            ST_INIT: begin
                clear = 1'b1;
                if (start) begin
                    turn_d = first_player;
                    st_d   = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (btn_sel) begin
                    st_d = ST_HOLD;
                    if (!occ_q[cur_idx]) begin
                        occ_d[cur_idx] = 1'b1;
                        own_d[cur_idx] = turn_q;
                        cnt_d          = cnt_q + CW'(1);
                        st_d           = ST_CHECK;
                    end
                end else if (btn_up) begin
                    row_d = (row_q == '0) ? LAST : row_q - RW'(1);
                    st_d  = ST_HOLD;
                end else if (btn_down) begin
                    row_d = (row_q == LAST) ? '0 : row_q + RW'(1);
                    st_d  = ST_HOLD;
                end else if (btn_left) begin
                    col_d = (col_q == '0) ? LAST : col_q - RW'(1);
                    st_d  = ST_HOLD;
                end else if (btn_right) begin
                    col_d = (col_q == LAST) ? '0 : col_q + RW'(1);
                    st_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!any_btn) st_d = ST_IDLE;
            end
            ST_CHECK: begin
                // a completed line wins even if the same move filled the board
                if (line_win) begin
                    win_d = turn_q ? WIN_P2 : WIN_P1;
                    st_d  = ST_WIN;
                end else if (cnt_q == CW'(NN)) begin
                    win_d = WIN_DRAW;
                    st_d  = ST_DRAW;
                end else begin
                    turn_d = ~turn_q;
                    st_d   = ST_HOLD;
                end
            end
            default: begin
                if (start) begin
                    clear = 1'b1;
                    st_d  = ST_INIT;
                end
            end
        endcase
        if (clear) begin
            occ_d = '0;
            own_d = '0;
            row_d = CTR;
            col_d = CTR;
            cnt_d = '0;
            win_d = WIN_NONE;
        end
    end

    assign state_q    = st_q;
    assign cur_row    = row_q;
    assign cur_col    = col_q;
    assign turn       = turn_q;
    assign move_count = cnt_q;
    assign winner     = win_q;

    logic          pix_in_r, pix_in_c;
    logic [RW-1:0] pix_row, pix_col;
    logic [IW-1:0] pix_idx;
    logic          hl;

    // 11-bit compares so cell bounds near the screen edge never wrap
    always_comb begin
        pix_in_r = 1'b0;
        pix_in_c = 1'b0;
        pix_row  = '0;
        pix_col  = '0;
        for (int i = 0; i < N; i++) begin
            if ({1'b0, vcount} >= 11'(ORIGIN_Y + i*PITCH) &&
                {1'b0, vcount} <= 11'(ORIGIN_Y + i*PITCH + CELL - 1)) begin
                pix_in_r = 1'b1;
                pix_row  = RW'(i);
            end
            if ({1'b0, hcount} >= 11'(ORIGIN_X + i*PITCH) &&
                {1'b0, hcount} <= 11'(ORIGIN_X + i*PITCH + CELL - 1)) begin
                pix_in_c = 1'b1;
                pix_col  = RW'(i);
            end
        end
    end

    assign pix_idx = IW'(pix_row) * IW'(N) + IW'(pix_col);

`ifdef GRID_WIN_HIGHLIGHT_EN
    logic [NN-1:0] win_mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_mask_q <= '0;
        end else if (clear) begin
            win_mask_q <= '0;
        end else if (st_q == ST_CHECK && line_win) begin
            win_mask_q <= line_mask;
        end
    end

    assign hl = (st_q == ST_WIN) && win_mask_q[pix_idx];
`else
    logic unused_line_mask;
    assign unused_line_mask = ^line_mask;
    assign hl = 1'b0;
`endif

    always_comb begin
        rgb = WHITE;
        if (!bright) begin
            rgb = BLACK;
        end else if (pix_in_r && pix_in_c) begin
            if (hl)                                      rgb = YELLOW;
            else if (pix_row == row_q && pix_col == col_q) rgb = GREEN;
            else if (occ_q[pix_idx] && !own_q[pix_idx])  rgb = RED;
            else if (occ_q[pix_idx])                     rgb = BLACK;
            else                                         rgb = RICE;
        end
    end

endmodule

// File: tb/tb_grid_game_controller.sv
// Randomised and directed bench for grid_game_controller (N=3) against a board-level game model.
`timescale 1ns/1ps
module tb_grid_game_controller;
    import grid_game_pkg::*;

    localparam int N = 3, CELL = 100, GAP = 5, OX = 308, OY = 120, P = CELL + GAP;
    localparam logic [4:0] B_SEL = 5'b10000, B_UP = 5'b01000, B_DN = 5'b00100,
                           B_L = 5'b00010, B_R = 5'b00001, B_NONE = 5'b00000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0, first_player = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
    logic        bright = 1'b0;
    logic [9:0]  hcount = '0, vcount = '0;
    logic [11:0] rgb;
    logic [1:0]  cur_row, cur_col;
    logic        turn;
    logic [3:0]  move_count;
    logic [1:0]  winner;
    logic [2:0]  state_q;

    always #5 clk = ~clk;

    grid_game_controller #(.N(N), .CELL(CELL), .GAP(GAP), .ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
        .clk(clk), .rst(rst), .start(start), .first_player(first_player),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_sel(btn_sel), .bright(bright), .hcount(hcount), .vcount(vcount), .rgb(rgb),
        .cur_row(cur_row), .cur_col(cur_col), .turn(turn), .move_count(move_count),
        .winner(winner), .state_q(state_q)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit pix_fixed = 1'b0;

    // game model: board holds 0 empty, 1 P1, 2 P2
    state_t m_st;
    int     m_r, m_c, m_turn, m_cnt, m_win;
    int     board [N][N];
    bit     m_mask [N][N];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic void new_board();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                board[r][c]  = 0;
                m_mask[r][c] = 1'b0;
            end
        m_r = N / 2; m_c = N / 2; m_cnt = 0; m_win = 0;
        m_st = ST_INIT;
    endfunction

    function automatic void model_reset();
        new_board();
        m_turn = 0;
    endfunction

    function automatic bit lines_done(input int p);
        bit any = 1'b0;
        bit full;
        for (int r = 0; r < N; r++) begin
            full = 1'b1;
            for (int k = 0; k < N; k++) if (board[r][k] != p) full = 1'b0;
            if (full) begin any = 1'b1; for (int k = 0; k < N; k++) m_mask[r][k] = 1'b1; end
        end
        for (int c = 0; c < N; c++) begin
            full = 1'b1;
            for (int k = 0; k < N; k++) if (board[k][c] != p) full = 1'b0;
            if (full) begin any = 1'b1; for (int k = 0; k < N; k++) m_mask[k][c] = 1'b1; end
        end
        full = 1'b1;
        for (int k = 0; k < N; k++) if (board[k][k] != p) full = 1'b0;
        if (full) begin any = 1'b1; for (int k = 0; k < N; k++) m_mask[k][k] = 1'b1; end
        full = 1'b1;
        for (int k = 0; k < N; k++) if (board[k][N-1-k] != p) full = 1'b0;
        if (full) begin any = 1'b1; for (int k = 0; k < N; k++) m_mask[k][N-1-k] = 1'b1; end
        return any;
    endfunction

    function automatic void model_step();
        bit any_btn = btn_up | btn_down | btn_left | btn_right | btn_sel;
        case (m_st)
            ST_INIT: if (start) begin m_turn = int'(first_player); m_st = ST_IDLE; end
            ST_IDLE: begin
                if (btn_sel) begin
                    if (board[m_r][m_c] != 0) m_st = ST_HOLD;
                    else begin
                        board[m_r][m_c] = m_turn + 1;
                        m_cnt++;
                        m_st = ST_CHECK;
                    end
                end
                else if (btn_up)    begin m_r = (m_r + N - 1) % N; m_st = ST_HOLD; end
                else if (btn_down)  begin m_r = (m_r + 1) % N;     m_st = ST_HOLD; end
                else if (btn_left)  begin m_c = (m_c + N - 1) % N; m_st = ST_HOLD; end
                else if (btn_right) begin m_c = (m_c + 1) % N;     m_st = ST_HOLD; end
            end
            ST_HOLD: if (!any_btn) m_st = ST_IDLE;
            ST_CHECK: begin
                if (lines_done(m_turn + 1)) begin m_win = m_turn + 1; m_st = ST_WIN; end
                else if (m_cnt == N * N)   begin m_win = 3; m_st = ST_DRAW; end
                else begin m_turn = 1 - m_turn; m_st = ST_HOLD; end
            end
            default: if (start) new_board();
        endcase
    endfunction

    function automatic logic [11:0] exp_rgb();
        int x, y, r, c;
        if (!bright) return BLACK;
        x = int'(hcount) - OX;
        y = int'(vcount) - OY;
        if (x < 0 || y < 0 || x >= N * P || y >= N * P || (x % P) >= CELL || (y % P) >= CELL)
            return WHITE;
        c = x / P;
        r = y / P;
`ifdef GRID_WIN_HIGHLIGHT_EN
        if (m_st == ST_WIN && m_mask[r][c]) return YELLOW;
`endif
        if (r == m_r && c == m_c) return GREEN;
        if (board[r][c] == 1) return RED;
        if (board[r][c] == 2) return BLACK;
        return RICE;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("state", int'(state_q), int'(m_st));
            check("cur_row", int'(cur_row), m_r);
            check("cur_col", int'(cur_col), m_c);
            check("turn", int'(turn), m_turn);
            check("move_count", int'(move_count), m_cnt);
            check("winner", int'(winner), m_win);
            check("rgb", int'(rgb), int'(exp_rgb()));
        end
    end

    task automatic drive(input logic [4:0] b, input bit s);
        {btn_sel, btn_up, btn_down, btn_left, btn_right} = b;
        start = s;
        if (!pix_fixed) begin
            bright = ($urandom_range(0, 7) != 0);
            hcount = 10'($urandom_range(280, 680));
            vcount = 10'($urandom_range(100, 460));
        end
        @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [4:0] b);
        drive(b, 1'b0);
        drive(B_NONE, 1'b0);
        drive(B_NONE, 1'b0);
    endtask

    task automatic new_game(input bit fp);
        rst = 1'b1;
        model_reset();
        drive(B_NONE, 1'b0);
        rst = 1'b0;
        first_player = fp;
        drive(B_NONE, 1'b1);
        drive(B_NONE, 1'b0);
    endtask

    task automatic goto_cell(input int r, input int c);
        for (int k = 0; k < N && m_r != r; k++) press(B_DN);
        for (int k = 0; k < N && m_c != c; k++) press(B_R);
    endtask

    task automatic place(input int r, input int c);
        goto_cell(r, c);
        press(B_SEL);
    endtask

    task automatic look(input int px, input int py);
        pix_fixed = 1'b1;
        bright = 1'b1;
        hcount = 10'(px);
        vcount = 10'(py);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        drive(B_NONE, 1'b0);
        cmp_en = 1'b1;
        drive(B_NONE, 1'b0);
        check("reset_state", int'(state_q), 0);
        check("reset_row", int'(cur_row), 1);
        check("reset_col", int'(cur_col), 1);
        check("reset_count", int'(move_count), 0);

        // cursor wraps on the right edge
        new_game(1'b0);
        press(B_R); check("right1_col", int'(cur_col), 2);
        press(B_R); check("right2_col", int'(cur_col), 0);
        press(B_R); check("right3_col", int'(cur_col), 1);
        check("right_row", int'(cur_row), 1);
        check("right_turn", int'(turn), 0);

        // P1 completes row 0
        new_game(1'b0);
        place(0, 0); place(1, 0); place(0, 1); place(1, 1);
        goto_cell(0, 2);
        drive(B_SEL, 1'b0);
        check("win_lat1_winner", int'(winner), 0);
        drive(B_NONE, 1'b0);
        check("win_lat2_winner", int'(winner), 1);
        check("win_state", int'(state_q), int'(ST_WIN));
        press(B_L); press(B_SEL);
        check("frozen_count", int'(move_count), 5);
        check("frozen_col", int'(cur_col), 2);
        look(OX + 50, OY + 50);
`ifdef GRID_WIN_HIGHLIGHT_EN
        check("rgb_win_cell", int'(rgb), 'hFF0);
`else
        check("rgb_p1_cell", int'(rgb), 'hF00);
`endif
        look(OX + CELL + 2, OY + 50);
        check("rgb_gap", int'(rgb), 'hFFF);
        look(OX + 2 * P + 50, OY + 2 * P + 50);
        check("rgb_empty", int'(rgb), 'hFEB);
        bright = 1'b0; #1;
        check("rgb_dark", int'(rgb), 0);
        pix_fixed = 1'b0;
        drive(B_NONE, 1'b1);
        check("restart_state", int'(state_q), int'(ST_INIT));
        check("restart_count", int'(move_count), 0);
        check("restart_winner", int'(winner), 0);

        // second select on an occupied cell is ignored
        new_game(1'b0);
        press(B_SEL);
        press(B_SEL);
        check("dup_count", int'(move_count), 1);
        check("dup_turn", int'(turn), 1);

        // full board without a line: X O X / X O O / O X X
        new_game(1'b0);
        place(0, 0); place(0, 1); place(0, 2); place(1, 1); place(1, 0);
        place(1, 2); place(2, 1); place(2, 0); place(2, 2);
        check("draw_winner", int'(winner), 3);
        check("draw_state", int'(state_q), int'(ST_DRAW));
        check("draw_count", int'(move_count), 9);

        // up+sel held: select wins priority, one action per press
        new_game(1'b0);
        for (int k = 0; k < 4; k++) drive(B_UP | B_SEL, 1'b0);
        check("upsel_row", int'(cur_row), 1);
        check("upsel_count", int'(move_count), 1);
        check("upsel_hold", int'(state_q), int'(ST_HOLD));
        drive(B_NONE, 1'b0);
        check("upsel_release", int'(state_q), int'(ST_IDLE));

        // P2 moves first and takes the anti-diagonal
        new_game(1'b1);
        place(0, 2); place(0, 0); place(1, 1); place(0, 1); place(2, 0);
        check("anti_winner", int'(winner), 2);
        look(OX + P + 50, OY + P + 50);
`ifdef GRID_WIN_HIGHLIGHT_EN
        check("rgb_anti_hl", int'(rgb), 'hFF0);
`else
        check("rgb_anti_p2", int'(rgb), 'h000);
`endif
        pix_fixed = 1'b0;

        // random play with occasional restarts and resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                model_reset();
                drive(B_NONE, 1'b0);
                rst = 1'b0;
            end else begin
                first_player = 1'($urandom_range(0, 1));
                drive(($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : B_NONE,
                      ($urandom_range(0, 24) == 0));
            end
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
